reg_index_serializer: RTL

- Encoder-side companion to the register-file write-select decoder.
- Accepts a 32-bit register mask and emits the 5-bit index of each set bit, lowest first, one per cycle, over a valid/ready stream.
- Sits between multi-register instructions (load/store-multiple style masks) and the register-file write/read index ports.

---
 rtl/reg_enc_pkg.sv | 7 +
 rtl/reg_index_serializer_lsb_priority_encoder.sv | 17 +
 rtl/reg_index_serializer.sv | 72 +++++++
 3 files changed

// File: rtl/reg_enc_pkg.sv
// reg_enc_pkg: shared sizes and types for the register index serializer
package reg_enc_pkg;
    localparam int N_REGS = 32;
    localparam int IDX_W = 5;
    typedef enum logic {S_IDLE, S_BUSY} enc_state_t;
    typedef logic [IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_index_serializer_lsb_priority_encoder.sv
// lsb_priority_encoder: index of the lowest set bit plus an any-set flag
module lsb_priority_encoder
    import reg_enc_pkg::*;
#(
    parameter int N = N_REGS,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    output logic [IDXW-1:0] idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = vec[i] ? IDXW'(i) : idx;
    end
    assign any = |vec;
endmodule

// File: rtl/reg_index_serializer.sv
// reg_index_serializer: streams set-bit indices of a mask, lowest first; REG_ENC_ONEHOT_EN adds out_onehot
module reg_index_serializer
    import reg_enc_pkg::*;
#(
    parameter int N = N_REGS,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [N-1:0]    load_mask,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic [IDXW:0]   remaining,
    output logic            done
`ifdef REG_ENC_ONEHOT_EN
    ,
    output logic [N-1:0]    out_onehot
`endif
);
    enc_state_t state, state_n;
    logic [N-1:0] pending, pending_n;
    logic done_n, any;
    lsb_priority_encoder #(.N(N), .IDXW(IDXW)) u_enc (
        .vec(pending),
        .idx(out_idx),
        .any(any)
    );
    assign out_valid = (state == S_BUSY) & any;
    assign load_ready = (state == S_IDLE) & ~reset;
    assign out_last = remaining == (IDXW+1)'(1);
    always_comb begin
        remaining = '0;
        for (int i = 0; i < N; i++) remaining = remaining + (IDXW+1)'(pending[i]);
    end
`ifdef REG_ENC_ONEHOT_EN
    assign out_onehot = out_valid ? (N'(1) << out_idx) : '0;
`endif
    // flush outranks load and transfer
    always_comb begin
        state_n = state;
        pending_n = pending;
        done_n = 1'b0;
        if (flush) begin
            state_n = S_IDLE;
            pending_n = '0;
        end else if (load_valid && load_ready) begin
            pending_n = load_mask;
            state_n = |load_mask ? S_BUSY : S_IDLE;
            done_n = ~|load_mask;
        end else if (out_valid && out_ready) begin
            pending_n = pending & ~(N'(1) << out_idx);
            state_n = out_last ? S_IDLE : S_BUSY;
            done_n = out_last;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pending <= '0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            pending <= pending_n;
            done <= done_n;
        end
    end
endmodule
